ternary_lane_sequencer: RTL and testbench

- Command-driven controller that sequences a bank of LANES ternary lane ALUs through one DOT, TGEMM or MUL pass.
- Accepts a command (op, length, base address, zero-skip) over a valid/ready handshake.
- Clears the lane accumulators, streams length element addresses to the shared weight/trit buffer (1-cycle read latency), drives lane enables aligned to the read data, then signals completion.
- Sits between the fabric command decoder and the lane array.

---
 rtl/ternary_lane_sequencer.sv | 124 ++++++++++++
 tb/tb_ternary_lane_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_lane_sequencer.sv
// Command-driven sequencer: clears the lane accumulators, streams buffer reads
// and drives lane enables aligned to the 1-cycle buffer read data.
module ternary_lane_sequencer #(
    parameter int unsigned LANES = 4,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_op,
    input  logic [AW-1:0]    cmd_len,
    input  logic [AW-1:0]    cmd_base,
    input  logic             cmd_zero_skip,
    input  logic             abort,
    input  logic             stall,
    output logic             buf_rd_en,
    output logic [AW-1:0]    buf_rd_addr,
    output logic             lane_rst,
    output logic [LANES-1:0] lane_enable,
    output logic [31:0]      exec_hints,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    elems_issued
);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   len_q, len_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hints_q, hints_d;
    logic            bad_q, bad_d;
    logic            en_q, en_d;
    logic            op_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            hints_q <= '0;
            bad_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            hints_q <= hints_d;
            bad_q   <= bad_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        hints_d     = hints_q;
        bad_d       = bad_q;
        en_d        = 1'b0;
        cmd_ready   = 1'b0;
        lane_rst    = 1'b0;
        buf_rd_en   = 1'b0;
        buf_rd_addr = '0;
        done        = 1'b0;
        err         = 1'b0;
        op_ok       = (cmd_op == 8'h01) || (cmd_op == 8'h03) || (cmd_op == 8'h06);

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    base_d  = cmd_base;
                    cnt_d   = '0;
                    bad_d   = !op_ok;
                    hints_d = {14'b0, cmd_zero_skip, 9'b0, cmd_op};
                    state_d = op_ok ? CLEAR : DONE;
                end
            end
            CLEAR: begin
                lane_rst = 1'b1;
                if (abort)              state_d = IDLE;
                else if (len_q == '0)   state_d = DONE;
                else                    state_d = STREAM;
            end
            STREAM: begin
                // A read issued in the abort cycle still counts, but its
                // enable is dropped so the lanes never see the data.
                if (!stall) begin
                    buf_rd_en   = 1'b1;
                    buf_rd_addr = base_q + cnt_q;
                    cnt_d       = cnt_q + AW'(1);
                    en_d        = !abort;
                end
                if (abort)
                    state_d = IDLE;
                else if (!stall && (cnt_q == len_q - AW'(1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                state_d = abort ? IDLE : DONE;
            end
            DONE: begin
                done    = 1'b1;
                err     = bad_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign lane_enable  = {LANES{en_q}};
    assign exec_hints   = hints_q;
    assign busy         = (state_q != IDLE);
    assign elems_issued = cnt_q;

endmodule

// File: tb/tb_ternary_lane_sequencer.sv
// Randomised scoreboard bench for ternary_lane_sequencer: the driver predicts
// read, clear, enable and completion events; a monitor matches them as they occur.
module tb_ternary_lane_sequencer;

    localparam int unsigned LANES = 4;
    localparam int unsigned AW    = 10;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_op = '0;
    logic [AW-1:0]    cmd_len = '0;
    logic [AW-1:0]    cmd_base = '0;
    logic             cmd_zero_skip = 1'b0;
    logic             abort = 1'b0;
    logic             stall = 1'b0;
    logic             buf_rd_en;
    logic [AW-1:0]    buf_rd_addr;
    logic             lane_rst;
    logic [LANES-1:0] lane_enable;
    logic [31:0]      exec_hints;
    logic             busy;
    logic             done;
    logic             err;
    logic [AW-1:0]    elems_issued;

    ternary_lane_sequencer #(.LANES(LANES), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_base(cmd_base), .cmd_zero_skip(cmd_zero_skip),
        .abort(abort), .stall(stall),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .lane_rst(lane_rst),
        .lane_enable(lane_enable), .exec_hints(exec_hints), .busy(busy),
        .done(done), .err(err), .elems_issued(elems_issued)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int unsigned cyc; int unsigned addr; } rd_t;
    typedef struct { int unsigned cyc; bit err; int unsigned elems; } done_t;

    rd_t         rd_q[$];
    int unsigned en_q[$];
    int unsigned rst_q[$];
    done_t       done_q[$];
    logic [31:0] exp_hints = '0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT event must match the oldest predicted one.
    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            if (buf_rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check("rd_cycle", cyc, r.cyc);
                    check("rd_addr", buf_rd_addr, r.addr);
                end
            end
            if (lane_rst) begin
                if (rst_q.size() == 0) check("lane_rst_unexpected", 1, 0);
                else check("lane_rst_cycle", cyc, rst_q.pop_front());
            end
            if (lane_enable != '0) begin
                check("enable_all_bits", lane_enable, {LANES{1'b1}});
                check("hints_during_enable", exec_hints, exp_hints);
                if (en_q.size() == 0) check("enable_unexpected", 1, 0);
                else check("enable_cycle", cyc, en_q.pop_front());
            end
            if (done) begin
                check("done_cmd_ready", cmd_ready, 0);
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_err", err, d.err);
                    check("done_elems", elems_issued, d.elems);
                end
            end else if (err) begin
                check("err_without_done", 1, 0);
            end
        end
    end

    // Issues one command in the current (IDLE) cycle and predicts its events
    // from the cycle-level rules: CLEAR one cycle after accept, STREAM from two
    // cycles after, enable one cycle after each read, DONE two after the last read.
    task automatic run_cmd(input logic [7:0] op, input int len, input int base,
                           input logic zs, input int abort_at, input int stall_mode);
        int unsigned c;
        int          t;
        int          reads;
        bit          aborted;
        bit          st;
        bit          s[$];
        bit          valid_op;
        done_t       d;

        c        = cyc;
        valid_op = (op == 8'h01) || (op == 8'h03) || (op == 8'h06);
        check("ready_in_idle", cmd_ready, 1);
        exp_hints = {14'b0, zs, 9'b0, op};
        aborted   = 1'b0;
        reads     = 0;
        d.cyc = 0; d.err = 1'b0; d.elems = 0;

        if (!valid_op) begin
            d.cyc = c + 1; d.err = 1'b1; d.elems = 0;
            done_q.push_back(d);
        end else begin
            rst_q.push_back(c + 1);
            if (len == 0) begin
                d.cyc = c + 2; d.elems = 0;
                done_q.push_back(d);
            end else begin
                t = 0;
                forever begin
                    if (stall_mode == 1 && t < 3 * len + 8) st = ($urandom_range(0, 3) == 0);
                    else st = (stall_mode == 2 && t == 1);
                    s.push_back(st);
                    if (!st) begin
                        rd_t r;
                        r.cyc  = c + 2 + t;
                        r.addr = (base + reads) % (1 << AW);
                        rd_q.push_back(r);
                        reads++;
                        if (abort_at != t + 1) en_q.push_back(c + 3 + t);
                    end
                    if (abort_at == t + 1) begin aborted = 1'b1; break; end
                    if (reads == len) begin
                        d.cyc = c + 4 + t; d.elems = reads;
                        done_q.push_back(d);
                        break;
                    end
                    t++;
                end
            end
        end

        cmd_valid = 1'b1; cmd_op = op; cmd_len = AW'(len); cmd_base = AW'(base);
        cmd_zero_skip = zs; stall = $urandom_range(0, 1); abort = $urandom_range(0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 8'($urandom); cmd_len = AW'($urandom);
        cmd_base = AW'($urandom); cmd_zero_skip = $urandom_range(0, 1);
        stall = $urandom_range(0, 1); abort = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1;
            stall = s[i];
            abort = (abort_at == i + 1);
        end
        @(posedge clk); #1;
        stall = 1'b0; abort = 1'b0;
        if (aborted) begin
            check("abort_busy", busy, 0);
            check("abort_enable", lane_enable, 0);
            check("abort_done", done, 0);
            check("abort_elems", elems_issued, reads);
        end else begin
            while (cyc <= d.cyc) begin
                @(posedge clk); #1;
            end
            check("post_done_busy", busy, 0);
            check("post_done_elems_held", elems_issued, d.elems);
            check("post_done_hints_held", exec_hints, exp_hints);
        end
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] op;
        int         len;
        int         ab;

        // Reset held with a command offered.
        cmd_valid = 1'b1; cmd_op = 8'h01; cmd_len = 10'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", buf_rd_en, 0);
        check("rst_rd_addr", buf_rd_addr, 0);
        check("rst_lane_rst", lane_rst, 0);
        check("rst_enable", lane_enable, 0);
        check("rst_hints", exec_hints, 0);
        check("rst_elems", elems_issued, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        run_cmd(8'h01, 4, 10'h3FE, 1'b0, 0, 0);
        check("dot_hints", exec_hints, 32'h0000_0001);
        run_cmd(8'h06, 3, 10'h100, 1'b1, 0, 2);
        check("tgemm_hints", exec_hints, 32'h0002_0006);
        run_cmd(8'h01, 0, 10'h055, 1'b0, 0, 0);
        run_cmd(8'h07, 5, 10'h010, 1'b1, 0, 0);
        run_cmd(8'h01, 8, 10'h020, 1'b0, 2, 0);
        run_cmd(8'h03, 2, 10'h3FF, 1'b0, 0, 0);
        run_cmd(8'h06, 1023, 10'h3F0, 1'b1, 0, 1);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 8'($urandom);
                while (op == 8'h01 || op == 8'h03 || op == 8'h06) op = op + 8'd1;
            end else begin
                case ($urandom_range(0, 2))
                    0: op = 8'h01;
                    1: op = 8'h03;
                    default: op = 8'h06;
                endcase
            end
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            ab  = ($urandom_range(0, 4) == 0 && len > 0) ? $urandom_range(1, len + 2) : 0;
            run_cmd(op, len, $urandom_range(0, 1023), $urandom_range(0, 1), ab, 1);
            repeat ($urandom_range(0, 2)) begin
                abort = $urandom_range(0, 1);
                stall = $urandom_range(0, 1);
                @(posedge clk); #1;
            end
            abort = 1'b0; stall = 1'b0;
        end

        // Asynchronous reset in the middle of a stream.
        mon_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = 8'h01; cmd_len = 10'd20; cmd_base = 10'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midstream_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_en", buf_rd_en, 0);
        check("async_rst_enable", lane_enable, 0);
        check("async_rst_elems", elems_issued, 0);
        check("async_rst_hints", exec_hints, 0);
        check("async_rst_ready", cmd_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_q.delete(); en_q.delete(); rst_q.delete(); done_q.delete();
        mon_en = 1'b1;
        run_cmd(8'h03, 5, 10'h200, 1'b1, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("left_reads", rd_q.size(), 0);
        check("left_enables", en_q.size(), 0);
        check("left_clears", rst_q.size(), 0);
        check("left_dones", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
